divider_int: RTL
================

Name: divider_int

Overview:
- Pipelined signed integer divider, the inverse of the pipelined integer multiplier in the arith library.
- Computes quotient and remainder of two's-complement operands using restoring division, one quotient bit per pipeline stage.
- Sits beside the multiplier in the image-processing datapath, for normalisation and scaling.
- Accepts one operation per cycle, has a valid-tagged pipeline and a global stall.

Parameters:
OPP_W  8  operand width in bits; dividend, divisor, quotient and remainder are all OPP_W wide; minimum 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  when high, every pipeline register holds its value and inputs are ignored
in_valid  input  1  opp_a/opp_b are valid this cycle
opp_a  input  OPP_W  dividend, two's complement
opp_b  input  OPP_W  divisor, two's complement
out_valid  output  1  quotient/remainder/div_by_zero are valid
quotient  output  OPP_W  signed quotient, truncated toward zero
remainder  output  OPP_W  signed remainder, same sign as dividend (or zero)
div_by_zero  output  1  opp_b was zero for this result

Behaviour:
- Reset: sampled on a clk edge with reset=1. Clears every pipeline register, including all valid bits; outputs go to out_valid=0, quotient=0, remainder=0, div_by_zero=0. Reset has priority over stall.
- Reset mid-operation: all in-flight operations are discarded; no out_valid pulse results from them.
- Stage 0, input register: on an edge with stall=0, latches:
  - |opp_a| and |opp_b| as OPP_W-bit unsigned values (|-2^(W-1)| = 2^(W-1), which fits unsigned);
  - sign_q = a_msb ^ b_msb;
  - sign_r = a_msb;
  - dbz = (opp_b == 0);
  - the original opp_a, kept for the divide-by-zero result;
  - valid = in_valid.
  - Data registers load regardless of in_valid; only the valid bit qualifies them.
- Stages 1..OPP_W, one restoring step each, MSB first:
  - partial remainder P (OPP_W+1 bits) = {P_prev, next dividend bit};
  - if P >= |b|: P = P - |b| and the quotient bit is 1; else the quotient bit is 0.
  - Divisor magnitude, signs, dbz, original dividend and valid travel alongside.
- Output stage, registered:
  - quotient = sign_q ? -Qmag : Qmag, truncated to OPP_W bits;
  - remainder = sign_r ? -Rmag : Rmag;
  - out_valid = the stage-OPP_W valid bit.
- Divide by zero: output stage forces quotient = all ones (-1), remainder = original opp_a, div_by_zero=1. div_by_zero is 0 for every other result.
- Overflow, -2^(W-1) / -1: quotient wraps to -2^(W-1), remainder 0. No flag.
- Latency: in_valid sampled at edge n with no stall in flight gives out_valid high for the cycle following edge n+OPP_W+1. For OPP_W=8 that is 9 edges.
- Each stall cycle adds one cycle of latency.
- Throughput: one operation per non-stalled cycle. Back-to-back inputs yield back-to-back results in order.
- No backpressure beyond stall. While stall=1, outputs hold their values, including out_valid, so a held out_valid=1 marks the same result, not a new one.
- Bubbles (in_valid=0) propagate as out_valid=0. Outputs carry don't-care data while out_valid=0.

Test Plan (OPP_W=8):
- Reset, then 100/7 at edge n -> at edge n+9 out_valid=1, quotient=14, remainder=2, div_by_zero=0; out_valid=0 the cycle after.
- Sign cases, one per cycle back-to-back: -100/7, 100/-7, -100/-7, 0/5 -> consecutive results (-14,-2), (-14,2), (14,-2), (0,0).
- Edge values: -128/-1 -> (-128,0); -128/1 -> (-128,0); 127/-128 -> (0,127); -128/-128 -> (1,0).
- Divide by zero: 5/0 -> quotient=0xFF, remainder=5, div_by_zero=1; -3/0 -> quotient=0xFF, remainder=0xFD, div_by_zero=1.
- Stall: stream 10 operations with stall high for 3 cycles mid-stream -> all 10 results correct, in order, latency +3 for those in flight; outputs frozen during stall.
- Reset mid-stream: assert reset for 1 cycle with 5 operations in flight -> outputs zeroed on that edge, no out_valid pulse from them. A new op right after reset returns at its normal latency.

Source files
------------

// File: rtl/divider_int.sv
// divider_int: pipelined signed integer divider (restoring, one quotient bit
// per stage). Works on operand magnitudes and applies the signs at the end.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; clears every pipeline register
//   stall        holds every pipeline register and ignores the inputs
//   in_valid     opp_a / opp_b are valid this cycle
//   opp_a        dividend, two's complement, OPP_W bits
//   opp_b        divisor, two's complement, OPP_W bits
//   out_valid    quotient / remainder / div_by_zero are valid
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, same sign as the dividend (or zero)
//   div_by_zero  opp_b was zero for this result
//
// Pipeline: input register (stage 0), OPP_W restoring steps (stages 1..OPP_W),
// and a registered output stage. Latency is OPP_W+1 edges.
module divider_int #(
    parameter int OPP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    in_valid,
    input  logic signed [OPP_W-1:0] opp_a,
    input  logic signed [OPP_W-1:0] opp_b,
    output logic                    out_valid,
    output logic signed [OPP_W-1:0] quotient,
    output logic signed [OPP_W-1:0] remainder,
    output logic                    div_by_zero
);

    localparam int W = OPP_W;
    localparam logic [W-1:0] ONE = W'(1);

    // Magnitude of a two's-complement value; the most negative value maps to
    // 2^(W-1), which is representable as an unsigned W-bit number.
    function automatic logic [W-1:0] mag_f(input logic [W-1:0] v);
        mag_f = v[W-1] ? (~v + ONE) : v;
    endfunction

    // Conditional two's-complement negation, wrapping to W bits.
    function automatic logic [W-1:0] neg_if_f(input logic neg, input logic [W-1:0] v);
        neg_if_f = neg ? (~v + ONE) : v;
    endfunction

    // Per-stage state. aq holds the unconsumed dividend bits at the top and
    // the quotient bits shifted in at the bottom; pr is the partial remainder,
    // which always stays below |b| and therefore fits in W bits.
    logic [W-1:0] pr_d    [0:W];
    logic [W-1:0] pr_q    [0:W];
    logic [W-1:0] aq_d    [0:W];
    logic [W-1:0] aq_q    [0:W];
    logic [W-1:0] bmag_d  [0:W-1];
    logic [W-1:0] bmag_q  [0:W-1];
    logic [W-1:0] aorig_d [0:W];
    logic [W-1:0] aorig_q [0:W];
    logic         sgnq_d  [0:W];
    logic         sgnq_q  [0:W];
    logic         sgnr_d  [0:W];
    logic         sgnr_q  [0:W];
    logic         dbz_d   [0:W];
    logic         dbz_q   [0:W];
    logic         vld_d   [0:W];
    logic         vld_q   [0:W];

    logic         out_valid_d, out_valid_q;
    logic [W-1:0] quotient_d, quotient_q;
    logic [W-1:0] remainder_d, remainder_q;
    logic         div_by_zero_d, div_by_zero_q;

    always_comb begin
        // Stage 0: input register
        pr_d[0]    = '0;
        aq_d[0]    = mag_f(opp_a);
        bmag_d[0]  = mag_f(opp_b);
        aorig_d[0] = opp_a;
        sgnq_d[0]  = opp_a[W-1] ^ opp_b[W-1];
        sgnr_d[0]  = opp_a[W-1];
        dbz_d[0]   = (opp_b == '0);
        vld_d[0]   = in_valid;

        // Stages 1..W: one restoring step each, dividend MSB first
        for (int k = 1; k <= W; k++) begin
            if ({pr_q[k-1], aq_q[k-1][W-1]} >= {1'b0, bmag_q[k-1]}) begin
                pr_d[k] = W'({pr_q[k-1], aq_q[k-1][W-1]} - {1'b0, bmag_q[k-1]});
                aq_d[k] = {aq_q[k-1][W-2:0], 1'b1};
            end else begin
                pr_d[k] = W'({pr_q[k-1], aq_q[k-1][W-1]});
                aq_d[k] = {aq_q[k-1][W-2:0], 1'b0};
            end
            aorig_d[k] = aorig_q[k-1];
            sgnq_d[k]  = sgnq_q[k-1];
            sgnr_d[k]  = sgnr_q[k-1];
            dbz_d[k]   = dbz_q[k-1];
            vld_d[k]   = vld_q[k-1];
        end
        for (int k = 1; k < W; k++) begin
            bmag_d[k] = bmag_q[k-1];
        end

        // Output stage: apply signs, override for divide by zero
        out_valid_d   = vld_q[W];
        div_by_zero_d = dbz_q[W];
        if (dbz_q[W]) begin
            quotient_d  = '1;
            remainder_d = aorig_q[W];
        end else begin
            quotient_d  = neg_if_f(sgnq_q[W], aq_q[W]);
            remainder_d = neg_if_f(sgnr_q[W], pr_q[W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= W; k++) begin
                pr_q[k]    <= '0;
                aq_q[k]    <= '0;
                aorig_q[k] <= '0;
                sgnq_q[k]  <= 1'b0;
                sgnr_q[k]  <= 1'b0;
                dbz_q[k]   <= 1'b0;
                vld_q[k]   <= 1'b0;
            end
            for (int k = 0; k < W; k++) begin
                bmag_q[k] <= '0;
            end
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k <= W; k++) begin
                pr_q[k]    <= pr_d[k];
                aq_q[k]    <= aq_d[k];
                aorig_q[k] <= aorig_d[k];
                sgnq_q[k]  <= sgnq_d[k];
                sgnr_q[k]  <= sgnr_d[k];
                dbz_q[k]   <= dbz_d[k];
                vld_q[k]   <= vld_d[k];
            end
            for (int k = 0; k < W; k++) begin
                bmag_q[k] <= bmag_d[k];
            end
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
